aemb2_intc: RTL

- Prioritised interrupt controller that drives the single core interrupt input (sys_int_i of the pipeline controller).
- Synchronises up to AEMB_IRQ external sources and holds pending/enable state.
- Exposes a 4-register config/claim slave port on the data-side bus.
- Sequences one interrupt at a time: assert → claim → end-of-interrupt. Nesting is not supported.

---
 rtl/aemb2_intc.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/aemb2_intc.sv
// aemb2_intc: prioritised interrupt controller feeding the single core interrupt input.
//
// Raw sources are synchronised, gated by the enable register and the lowest-indexed active
// source wins. One interrupt is sequenced at a time: assert -> claim -> end-of-interrupt.
//
// Optional feature macro: AEMB_INTC_EDGE_EN
//   undefined (default): level mode, pending = synchronised source level, PEND writes ignored.
//   defined            : edge mode, sticky pending bits set on rising edges, cleared by PEND
//                        W1C or by claiming that source (a set on the same edge wins).
//
// Ports:
//   sys_clk_i   system clock, all flops on posedge
//   sys_rst_i   asynchronous active-high reset
//   irq_i       raw asynchronous interrupt sources, bit 0 highest priority
//   cwb_stb_i   slave strobe, held until ack
//   cwb_we_i    1 = write, 0 = read
//   cwb_adr_i   register select: 0 PEND, 1 IER, 2 CLAIM, 3 EOI
//   cwb_dat_i   write data
//   cwb_dat_o   read data, valid with ack, zero otherwise
//   cwb_ack_o   single-cycle acknowledge
//   sys_int_o   registered interrupt request, high exactly while in the assert state
module aemb2_intc #(
  parameter int unsigned AEMB_IRQ = 8,
  parameter int unsigned AEMB_IRL = 3
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [AEMB_IRQ-1:0] irq_i,
  input  logic                cwb_stb_i,
  input  logic                cwb_we_i,
  input  logic [1:0]          cwb_adr_i,
  input  logic [31:0]         cwb_dat_i,
  output logic [31:0]         cwb_dat_o,
  output logic                cwb_ack_o,
  output logic                sys_int_o
);

  typedef enum logic [1:0] {StIdle, StAssert, StService} state_e;

  localparam logic [1:0] AdrPend  = 2'd0;
  localparam logic [1:0] AdrIer   = 2'd1;
  localparam logic [1:0] AdrClaim = 2'd2;
  localparam logic [1:0] AdrEoi   = 2'd3;

  state_e                state_q, state_d;
  logic [AEMB_IRQ-1:0]   irq_meta_q, irq_s_q;
  logic [AEMB_IRQ-1:0]   ier_q, ier_d;
  logic [AEMB_IRL-1:0]   isr_id_q, isr_id_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  int_q, int_d;

  logic [AEMB_IRQ-1:0]   pend;
  logic [AEMB_IRQ-1:0]   act;
  logic [AEMB_IRL-1:0]   sel;
  logic                  any;
  logic                  claim;
  logic                  eoi;
  logic [31:0]           rd_data;

  // ack_d doubles as the access strobe: every side effect lands on the edge ack rises.
  assign ack_d = cwb_stb_i & ~cwb_ack_o;

  // Two-flop synchroniser.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      irq_meta_q <= '0;
      irq_s_q    <= '0;
    end else begin
      irq_meta_q <= irq_i;
      irq_s_q    <= irq_meta_q;
    end
  end

`ifdef AEMB_INTC_EDGE_EN
  logic [AEMB_IRQ-1:0] irq_d_q;
  logic [AEMB_IRQ-1:0] pend_q, pend_d;
  logic [AEMB_IRQ-1:0] rise;
  logic [AEMB_IRQ-1:0] clr;

  assign rise = irq_s_q & ~irq_d_q;

  always_comb begin
    clr = '0;
    if (ack_d && cwb_we_i && cwb_adr_i == AdrPend) begin
      clr = cwb_dat_i[AEMB_IRQ-1:0];
    end
    if (claim) begin
      clr = clr | (AEMB_IRQ'(1) << sel);
    end
    // OR-ing rise last lets a fresh edge survive a simultaneous clear.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      irq_d_q <= '0;
      pend_q  <= '0;
    end else begin
      irq_d_q <= irq_s_q;
      pend_q  <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  assign pend = irq_s_q;
`endif

  assign act = pend & ier_q;
  assign any = |act;

  // Lowest set index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    sel = '0;
    for (int i = AEMB_IRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        sel = AEMB_IRL'(i);
      end
    end
  end

  assign claim = ack_d & ~cwb_we_i & (cwb_adr_i == AdrClaim) & (state_q == StAssert) & any;
  assign eoi   = ack_d & cwb_we_i & (cwb_adr_i == AdrEoi) & (state_q == StService);

  // Register file: IER update, claimed-id latch and read data.
  always_comb begin
    ier_d    = ier_q;
    isr_id_d = isr_id_q;
    if (ack_d && cwb_we_i && cwb_adr_i == AdrIer) begin
      ier_d = cwb_dat_i[AEMB_IRQ-1:0];
    end
    if (claim) begin
      isr_id_d = sel;
    end

    rd_data = '0;
    case (cwb_adr_i)
      AdrPend:  rd_data = 32'(pend);
      AdrIer:   rd_data = 32'(ier_q);
      AdrClaim: if (claim) rd_data = {28'h800_0000, 4'(sel)};
      default:  rd_data = '0;
    endcase

    dat_d = (ack_d && !cwb_we_i) ? rd_data : '0;
  end

  // FSM: state register.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any) state_d = StAssert;
      end
      StAssert: begin
        if (claim)     state_d = StService;
        else if (!any) state_d = StIdle;
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: output. Registered from the next state so sys_int_o tracks state_q exactly.
  always_comb begin
    int_d = (state_d == StAssert);
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      ier_q    <= '0;
      isr_id_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      int_q    <= 1'b0;
    end else begin
      ier_q    <= ier_d;
      isr_id_q <= isr_id_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      int_q    <= int_d;
    end
  end

  assign cwb_ack_o = ack_q;
  assign cwb_dat_o = dat_q;
  assign sys_int_o = int_q;

  // Upper write-data bits and the claimed id have no reader on this port.
  logic unused_bits;
  assign unused_bits = ^{cwb_dat_i[31:AEMB_IRQ], isr_id_q};

endmodule
